shift_rotate_pipe: RTL



---
 rtl/shift_rotate_pipe.sv | 79 +++++++
 1 files changed

// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe: C-stage log shifter/rotator (ROL/SLL/ROR/SRL), ROR gated by SHIFT_ROTATE_ROR_EN
module shift_rotate_pipe #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [1:0]   Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out
);
  logic [C-1:0] v_q, v_d;
  logic [N-1:0] d_q [C];
  logic [N-1:0] d_d [C];
  logic [N-1:0] x [C];
  logic [C-1:0] cnt_q [C-1];
  logic [C-1:0] cnt_d [C-1];
  logic [C-1:0] c_in [C];
  logic [1:0]   op_q [C-1];
  logic [1:0]   op_d [C-1];
  logic [1:0]   o_in [C];
  logic [1:0]   op_dec;
  logic         adv;

  // op bit1 selects right, bit0 selects zero fill; without ROR, 10 folds onto ROL
  function automatic logic [N-1:0] step(input logic [N-1:0] a, input logic [1:0] o, input int s);
    logic [N-1:0] wl, wr;
    wl = o[0] ? '0 : a >> (N - s);
`ifdef SHIFT_ROTATE_ROR_EN
    wr = o[0] ? '0 : a << (N - s);
`else
    wr = '0;
`endif
    return o[1] ? ((a >> s) | wr) : ((a << s) | wl);
  endfunction

`ifdef SHIFT_ROTATE_ROR_EN
  assign op_dec = Op;
`else
  assign op_dec = (Op == 2'b10) ? 2'b00 : Op;
`endif

  // global advance: every stage moves together or the whole pipe holds
  always_comb begin
    adv = !v_q[C-1] || out_ready;
    v_d = adv ? {v_q[C-2:0], in_valid} : v_q;
    x[0] = In;
    c_in[0] = Cnt;
    o_in[0] = op_dec;
    for (int k = 1; k < C; k++) begin
      x[k] = d_q[k-1];
      c_in[k] = cnt_q[k-1];
      o_in[k] = op_q[k-1];
    end
    for (int k = 0; k < C; k++)
      d_d[k] = adv ? (c_in[k][k] ? step(x[k], o_in[k], 1 << k) : x[k]) : d_q[k];
    for (int k = 0; k < C - 1; k++) begin
      cnt_d[k] = adv ? c_in[k] : cnt_q[k];
      op_d[k] = adv ? o_in[k] : op_q[k];
    end
  end

  // only valid bits are reset; data of an empty stage is don't-care
  always_ff @(posedge clk) begin
    v_q <= rst ? '0 : v_d;
    d_q <= d_d;
    cnt_q <= cnt_d;
    op_q <= op_d;
  end

  assign in_ready = adv;
  assign out_valid = v_q[C-1];
  assign Out = v_q[C-1] ? d_q[C-1] : '0;
endmodule
